// File: rtl/mig_ui_bram_responder.sv
// mig_ui_bram_responder
//   BRAM-backed stand-in for a MIG 7-series user interface. Commands and
//   write-data beats are queued in two 16-deep FIFOs and executed strictly
//   in acceptance order, one head command per cycle. Reads return after a
//   fixed pipeline delay; app_rdy can be throttled periodically to exercise
//   the initiator's backpressure handling.
// Ports:
//   clk, reset          clock / async active-high reset (BRAM contents kept)
//   calib_done          high CALIB_CYCLES cycles after reset release
//   app_en/cmd/addr/rdy command channel (000 write, 001 read)
//   app_wdf_*           write data channel (data, byte mask, end, wren, rdy)
//   app_rd_data*        read data return, no backpressure
//   err_cmd, err_end    sticky protocol violation flags
//   wr_cnt, rd_cnt      writes committed / read beats returned
module mig_ui_bram_responder #(
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 256,
  parameter int DEPTH_LOG2   = 12,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    calib_done,
  input  logic                    app_en,
  input  logic [2:0]              app_cmd,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_rdy,
  input  logic                    app_wdf_wren,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic                    app_wdf_end,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    err_cmd,
  output logic                    err_end,
  output logic [31:0]             wr_cnt,
  output logic [31:0]             rd_cnt
);
  localparam int FD = 16;
  localparam int MW = DATA_WIDTH/8;

  typedef struct packed {
    logic                  rd;
    logic [DEPTH_LOG2-1:0] idx;
  } cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [MW-1:0]         mask;
  } wdf_t;

  // ---------------- calibration ----------------
  logic [31:0] r_cal_cnt;
  logic        r_calib;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cal_cnt <= '0;
      r_calib   <= 1'b0;
    end else if (!r_calib) begin
      r_cal_cnt <= r_cal_cnt + 32'd1;
      if (r_cal_cnt == 32'(CALIB_CYCLES-1)) r_calib <= 1'b1;
    end
  end
  assign calib_done = r_calib;

  // ---------------- periodic app_rdy stall ----------------
  logic w_stall;
  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [31:0] r_stall_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      r_stall_cnt <= '0;
        else if (r_stall_cnt == 32'(STALL_PERIOD-1))    r_stall_cnt <= '0;
        else                                            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      assign w_stall = (r_stall_cnt == 32'(STALL_PERIOD-1));
    end else begin : g_nostall
      assign w_stall = 1'b0;
    end
  endgenerate

  // ---------------- FIFOs ----------------
  cmd_t       r_cq [FD];
  logic [3:0] r_cq_wp, r_cq_rp;
  logic [4:0] r_cq_cnt;
  wdf_t       r_wq [FD];
  logic [3:0] r_wq_wp, r_wq_rp;
  logic [4:0] r_wq_cnt;

  // Threshold at 15 leaves one spare slot; rdy is decoded from registers only.
  assign app_rdy     = r_calib & (r_cq_cnt < 5'd15) & ~w_stall;
  assign app_wdf_rdy = r_calib & (r_wq_cnt < 5'd15);

  logic w_cmd_acc, w_cmd_legal, w_cq_push, w_wq_push;
  logic w_do_rd, w_do_wr;
  cmd_t w_head;
  wdf_t w_whead;

  assign w_cmd_acc   = app_en & app_rdy;
  assign w_cmd_legal = (app_cmd == 3'b000) | (app_cmd == 3'b001);
  assign w_cq_push   = w_cmd_acc & w_cmd_legal;
  assign w_wq_push   = app_wdf_wren & app_wdf_rdy;
  assign w_head      = r_cq[r_cq_rp];
  assign w_whead     = r_wq[r_wq_rp];

  // A write head without data blocks everything behind it: strict ordering.
  assign w_do_rd = (r_cq_cnt != 5'd0) & w_head.rd;
  assign w_do_wr = (r_cq_cnt != 5'd0) & ~w_head.rd & (r_wq_cnt != 5'd0);

  // Address low 3 bits and high bits beyond the depth are don't-care.
  logic w_unused_addr;
  assign w_unused_addr = ^app_addr;

  always_ff @(posedge clk) begin
    if (w_cq_push) r_cq[r_cq_wp] <= '{rd: app_cmd[0], idx: app_addr[DEPTH_LOG2+2:3]};
    if (w_wq_push) r_wq[r_wq_wp] <= '{data: app_wdf_data, mask: app_wdf_mask};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cq_wp  <= '0;
      r_cq_rp  <= '0;
      r_cq_cnt <= '0;
      r_wq_wp  <= '0;
      r_wq_rp  <= '0;
      r_wq_cnt <= '0;
    end else begin
      if (w_cq_push)           r_cq_wp <= r_cq_wp + 4'd1;
      if (w_do_rd | w_do_wr)   r_cq_rp <= r_cq_rp + 4'd1;
      if (w_wq_push)           r_wq_wp <= r_wq_wp + 4'd1;
      if (w_do_wr)             r_wq_rp <= r_wq_rp + 4'd1;
      r_cq_cnt <= r_cq_cnt + {4'd0, w_cq_push} - {4'd0, (w_do_rd | w_do_wr)};
      r_wq_cnt <= r_wq_cnt + {4'd0, w_wq_push} - {4'd0, w_do_wr};
    end
  end

  // ---------------- BRAM ----------------
  logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] r_bram_dout;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      for (int b = 0; b < MW; b++)
        if (!w_whead.mask[b]) r_mem[w_head.idx][b*8 +: 8] <= w_whead.data[b*8 +: 8];
    end
    if (w_do_rd) r_bram_dout <= r_mem[w_head.idx];
  end

  // ---------------- read return pipeline ----------------
  // r_vld_pipe[0] qualifies r_bram_dout; stages 1..RD_LATENCY carry it out.
  logic [RD_LATENCY:0]                 r_vld_pipe;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] r_dpipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_dpipe    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LATENCY-1:0], w_do_rd};
      r_dpipe[1] <= r_bram_dout;
      for (int k = 2; k <= RD_LATENCY; k++) r_dpipe[k] <= r_dpipe[k-1];
    end
  end

  assign app_rd_data       = r_dpipe[RD_LATENCY];
  assign app_rd_data_valid = r_vld_pipe[RD_LATENCY];
  assign app_rd_data_end   = r_vld_pipe[RD_LATENCY];

  // ---------------- flags / counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cmd <= 1'b0;
      err_end <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (w_cmd_acc & ~w_cmd_legal)  err_cmd <= 1'b1;
      if (w_wq_push & ~app_wdf_end)  err_end <= 1'b1;
      wr_cnt <= wr_cnt + 32'(w_do_wr);
      // counted on the edge the beat appears at the output
      rd_cnt <= rd_cnt + 32'(r_vld_pipe[RD_LATENCY-1]);
    end
  end
endmodule
